// File: rtl/match_log_pkg.sv
// Shared defaults for the match event logger and its FIFO.
// The pointer width carries one wrap bit above the address so full and empty can be told apart.
package match_log_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/match_event_logger_if.sv
// Event stream from the logger to its consumer.
// Handshake: a transfer happens on a rising clk edge where evt_valid and evt_ready are both high;
// evt_valid never waits for evt_ready, and evt_ts is only meaningful while evt_valid is high.
interface match_event_logger_if #(
    parameter int TS_W = 16
) ();

    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;

    modport master (
        output evt_valid,
        output evt_ts,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ts,
        output evt_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and no read bypass.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import match_log_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign valid   = !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is never reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps rising edges of the detector match flag z and queues them for a consumer.
// Also keeps a saturating match count and a sticky overflow flag for dropped events.
module match_event_logger
    import match_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 z,
    input  logic                 clr,
    match_event_logger_if.master evt,
    output logic [CNT_W-1:0]     match_count,
    output logic                 overflow
);

    logic [TS_W-1:0] ts;
    logic            z_q;
    logic            evt_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_valid;
    logic [TS_W-1:0] fifo_dout;

    assign evt_fire  = z && !z_q;
    assign fifo_push = evt_fire && !clr;
    assign fifo_pop  = evt.evt_ready && fifo_valid && !clr;

    assign evt.evt_valid = fifo_valid;
    assign evt.evt_ts    = fifo_dout;

    sync_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (fifo_push),
        .din   (ts),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full)
    );

    // An event is dropped only when the FIFO is full and no pop frees a slot this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts          <= '0;
            z_q         <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clr) begin
            ts          <= '0;
            z_q         <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            ts  <= ts + 1'b1;
            z_q <= z;
            if (evt_fire && (match_count != '1)) match_count <= match_count + 1'b1;
            if (evt_fire && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger; a second instance with a 4-bit counter checks saturation.
module tb_match_event_logger;
    import match_log_pkg::*;

    localparam int TS_W   = 16;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 8;
    localparam int CNT2_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic z     = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    match_event_logger_if #(.TS_W(TS_W)) evt ();
    match_event_logger_if #(.TS_W(TS_W)) evt2 ();

    logic [CNT_W-1:0]  match_count;
    logic              overflow;
    logic [CNT2_W-1:0] match_count2;
    logic              overflow2;

    assign evt2.evt_ready = evt.evt_ready;

    match_event_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .z           (z),
        .clr         (clr),
        .evt         (evt),
        .match_count (match_count),
        .overflow    (overflow)
    );

    match_event_logger #(.TS_W(TS_W), .CNT_W(CNT2_W), .DEPTH(DEPTH)) dut_cnt4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .z           (z),
        .clr         (clr),
        .evt         (evt2),
        .match_count (match_count2),
        .overflow    (overflow2)
    );

    // Scoreboard: the expected FIFO contents plus the expected counters and flags.
    logic [TS_W-1:0] exp_q[$];
    logic [TS_W-1:0] ts_m;
    logic            zq_m;
    int              cnt_m;
    logic            ovf_m;
    int              vectors;
    int              miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ts_m  = '0;
        zq_m  = 1'b0;
        cnt_m = 0;
        ovf_m = 1'b0;
    endtask

    // Drive one cycle: check current outputs, update the model for the coming edge, then advance.
    task automatic step(input logic z_i, input logic rdy_i, input logic clr_i);
        logic [TS_W-1:0] head;
        logic            ev;
        z             = z_i;
        evt.evt_ready = rdy_i;
        clr           = clr_i;
        check("evt_valid", {31'd0, evt.evt_valid}, {31'd0, exp_q.size() != 0});
        check("match_count", {16'd0, match_count}, (cnt_m > 65535) ? 65535 : cnt_m);
        check("match_count_cnt4", {28'd0, match_count2}, (cnt_m > 15) ? 15 : cnt_m);
        check("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        check("overflow_cnt4", {31'd0, overflow2}, {31'd0, ovf_m});
        ev = z_i && !zq_m;
        if (clr_i) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0 && rdy_i) begin
                head = exp_q.pop_front();
                check("evt_ts_pop", {16'd0, evt.evt_ts}, {16'd0, head});
            end
            if (ev) begin
                cnt_m++;
                if (exp_q.size() < DEPTH) exp_q.push_back(ts_m);
                else ovf_m = 1'b1;
            end
            ts_m = ts_m + 1'b1;
            zq_m = z_i;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        evt.evt_ready = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("rst_evt_valid", {31'd0, evt.evt_valid}, 32'd0);
        check("rst_match_count", {16'd0, match_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-cycle pulse on cycle 5
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pulse_valid", {31'd0, evt.evt_valid}, 32'd1);
        check("pulse_ts", {16'd0, evt.evt_ts}, 32'd5);
        check("pulse_count", {16'd0, match_count}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // z held high cycles 10..14 gives one event
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("held_ts", {16'd0, evt.evt_ts}, 32'd10);
        check("held_count", {16'd0, match_count}, 32'd2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Fill to DEPTH, then an event coincident with a pop
        repeat (DEPTH) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("full_pop_ovf", {31'd0, overflow}, 32'd0);
        repeat (DEPTH) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // DEPTH+1 events with no consumer: last one dropped
        repeat (DEPTH + 1) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("drop_ovf", {31'd0, overflow}, 32'd1);
        check("drop_count", {16'd0, match_count}, 32'd20);
        check("sat_count4", {28'd0, match_count2}, 32'd15);
        repeat (DEPTH) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);

        // clr with 3 entries queued, coincident with an event
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        check("clr_valid", {31'd0, evt.evt_valid}, 32'd0);
        check("clr_count", {16'd0, match_count}, 32'd0);
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("clr_ts_zero", {16'd0, evt.evt_ts}, 32'd0);
        step(1'b0, 1'b1, 1'b0);

        // One entry queued, then push and pop together
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        repeat (2) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, evt.evt_valid}, 32'd0);
        check("async_rst_count", {16'd0, match_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("post_rst_ts", {16'd0, evt.evt_ts}, 32'd0);
        step(1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0), 1'b0);
        end
        repeat (DEPTH + 1) step(1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 The block SHALL have parameter TS_W, default 16, the timestamp width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, the match counter width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 8, the event FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have port z  input  1  the match flag from the upstream sequence detector, sampled every cycle.
REQ-007 The block SHALL have port clr  input  1  synchronous clear of all logger state.
REQ-008 The block SHALL have port evt_valid  output  1  high when the FIFO holds at least one event.
REQ-009 The block SHALL have port evt_ready  input  1  consumer accepts the head event when high together with evt_valid.
REQ-010 The block SHALL have port evt_ts  output  TS_W  timestamp of the head event; don't-care while evt_valid is low.
REQ-011 The block SHALL have port match_count  output  CNT_W  number of detected matches since reset or clr, saturating.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-013 A free-running cycle counter ts SHALL increment by 1 every cycle and wrap from 2^TS_W-1 to 0.
REQ-014 A registered copy z_q SHALL hold the previous cycle's z; an event SHALL be z=1 with z_q=0 (rising edge), so z held high N cycles yields one event.
REQ-015 On an event at edge n, the FIFO SHALL push the ts value current before edge n; evt_valid SHALL rise in the cycle after edge n (latency 1).
REQ-016 On each event, match_count SHALL increment by 1, holding at 2^CNT_W-1 with no wrap.
REQ-017 match_count SHALL increment on every event, including events dropped by the FIFO.
REQ-018 A pop SHALL occur on a rising edge when evt_valid=1 and evt_ready=1; evt_ts SHALL then present the next entry in FIFO order.
REQ-019 evt_ready while evt_valid=0 SHALL have no effect.
REQ-020 Push when full without a same-cycle pop SHALL discard the event, keep the FIFO contents, and set overflow to 1.
REQ-021 Push and pop in the same cycle when full SHALL both occur: occupancy stays DEPTH and overflow is unchanged.
REQ-022 Push and pop in the same cycle with exactly one entry SHALL leave one entry, the new event.
REQ-023 Push into an empty FIFO SHALL NOT bypass: evt_valid stays 0 during the push cycle.
REQ-024 clr=1 at an edge SHALL empty the FIFO and zero match_count, overflow, ts and z_q; clr SHALL take priority over a same-cycle event or pop.
REQ-025 overflow SHALL be cleared only by rst_n or clr.
REQ-026 Read and write pointers SHALL be log2(DEPTH)+1 bits, with full/empty derived from the MSB comparison; they wrap naturally.

Reset
REQ-027 While rst_n=0, outputs SHALL be evt_valid=0, match_count=0 and overflow=0; ts, z_q and the FIFO pointers SHALL be 0.
REQ-028 Deassertion of rst_n mid-operation SHALL resume from that all-zero state; FIFO storage contents need no reset.

Structure
REQ-029 A shared package match_log_pkg SHALL hold the TS_W, CNT_W and DEPTH defaults and a derived pointer-width function or constant.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo (data width TS_W, depth DEPTH), instantiated once; edge detection, counters and flags SHALL live in the top.

Verification
REQ-031 Reset, then z=1 for exactly cycle 5 -> evt_valid=1 from cycle 6, evt_ts=5, match_count=1.
REQ-032 z held high for cycles 10..14 -> exactly one event with evt_ts=10 and match_count=1.
REQ-033 9 events with evt_ready=0, DEPTH=8 -> 8 entries kept in arrival order, overflow=1, match_count=9; draining yields the first 8 timestamps in order.
REQ-034 FIFO full, event coincident with a pop -> occupancy stays 8, overflow stays 0, and the new timestamp is last out.
REQ-035 CNT_W=4, 17 events -> match_count holds at 15.
REQ-036 clr asserted in the same cycle as an event with 3 entries queued -> next cycle evt_valid=0, match_count=0, overflow=0, ts=0.
